slib_edge_capture: RTL and testbench



---
 rtl/slib_edge_pkg.sv | 32 +++
 rtl/slib_edge_filter_ch.sv | 97 +++++++++
 rtl/slib_edge_capture.sv | 91 +++++++++
 tb/tb_slib_edge_capture.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/slib_edge_pkg.sv
// slib_edge_pkg
//   Shared types and helpers for the slib edge-capture block.
//   - edge_mode_t : per-channel qualification of which edges set the
//                   pending flag.
//   - cnt_width   : width of the glitch-filter stability counter.
//   - mode_rise / mode_fall : decode of an edge_mode_t value.
package slib_edge_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  localparam int MAX_SYNC_STAGES = 4;

  // Counter only needs to reach FILTER_LEN-1; never narrower than one bit.
  function automatic int cnt_width(input int len);
    if (len <= 2) return 1;
    else          return $clog2(len);
  endfunction

  function automatic logic mode_rise(input edge_mode_t m);
    return (m == EDGE_RISE) || (m == EDGE_BOTH);
  endfunction

  function automatic logic mode_fall(input edge_mode_t m);
    return (m == EDGE_FALL) || (m == EDGE_BOTH);
  endfunction

endpackage

// File: rtl/slib_edge_filter_ch.sv
// slib_edge_filter_ch
//   One channel of the edge-capture block: input synchroniser, glitch
//   filter and registered rising/falling edge pulses on the filtered level.
//
//   Filter state table:
//     S == Q                   | input agrees with accepted level, counter idle
//     S != Q, CNT <  LEN-1     | new level being timed
//     S != Q, CNT == LEN-1     | new level accepted this cycle
//
// Ports:
//   CLK      in   clock, all state on rising edge
//   RSTN     in   synchronous reset, active low
//   D        in   raw (asynchronous) channel input
//   Q        out  filtered, synchronised level
//   RE       out  one-cycle pulse, cycle Q first shows 1
//   FE       out  one-cycle pulse, cycle Q first shows 0
//   RE_NEXT  out  value RE takes at the next edge (lets the parent register
//                 its pending flag on the same edge as Q/RE)
//   FE_NEXT  out  value FE takes at the next edge
module slib_edge_filter_ch
  import slib_edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 1
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic D,
  output logic Q,
  output logic RE,
  output logic FE,
  output logic RE_NEXT,
  output logic FE_NEXT
);

  localparam int              CW      = cnt_width(FILTER_LEN);
  localparam logic [CW-1:0]   CNT_MAX = CW'(FILTER_LEN - 1);

  logic          s;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          q_next;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = D;
    end else begin : g_sync
      logic [SYNC_STAGES:1] sync_q;

      always_ff @(posedge CLK) begin
        if (!RSTN) begin
          sync_q <= '0;
        end else begin
          sync_q[1] <= D;
          for (int k = 2; k <= SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
          end
        end
      end

      assign s = sync_q[SYNC_STAGES];
    end
  endgenerate

  // Any return of S to the accepted level restarts the timing, so a glitch
  // shorter than FILTER_LEN cycles never reaches Q.
  always_comb begin
    cnt_next = cnt;
    q_next   = Q;
    if (s == Q) begin
      cnt_next = '0;
    end else if (cnt == CNT_MAX) begin
      q_next   = s;
      cnt_next = '0;
    end else begin
      cnt_next = cnt + CW'(1);
    end
  end

  assign RE_NEXT = ~Q &  q_next;
  assign FE_NEXT =  Q & ~q_next;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      Q   <= 1'b0;
      cnt <= '0;
      RE  <= 1'b0;
      FE  <= 1'b0;
    end else begin
      Q   <= q_next;
      cnt <= cnt_next;
      RE  <= RE_NEXT;
      FE  <= FE_NEXT;
    end
  end

endmodule

// File: rtl/slib_edge_capture.sv
// slib_edge_capture
//   Multi-channel edge capture. Each channel is synchronised and filtered
//   independently (slib_edge_filter_ch); this level adds the sticky,
//   mode-qualified pending flags and the interrupt summary.
//
// Ports:
//   CLK   in   1         clock
//   RSTN  in   1         synchronous reset, active low
//   D     in   WIDTH     raw channel inputs
//   MODE  in   2*WIDTH   per channel [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   CLR   in   WIDTH     per-channel pending clear (level sensitive)
//   Q     out  WIDTH     filtered, synchronised levels
//   RE    out  WIDTH     rising-edge pulses
//   FE    out  WIDTH     falling-edge pulses
//   PEND  out  WIDTH     sticky pending flags
//   IRQ   out  1         OR of PEND
module slib_edge_capture
  import slib_edge_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 1
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic [WIDTH-1:0]     D,
  input  logic [2*WIDTH-1:0]   MODE,
  input  logic [WIDTH-1:0]     CLR,
  output logic [WIDTH-1:0]     Q,
  output logic [WIDTH-1:0]     RE,
  output logic [WIDTH-1:0]     FE,
  output logic [WIDTH-1:0]     PEND,
  output logic                 IRQ
);

  generate
    if (WIDTH < 1) begin : g_chk_width
      $error("slib_edge_capture: WIDTH must be at least 1");
    end
    if (SYNC_STAGES < 0 || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_chk_sync
      $error("slib_edge_capture: SYNC_STAGES must be in 0..4");
    end
    if (FILTER_LEN < 1) begin : g_chk_filter
      $error("slib_edge_capture: FILTER_LEN must be at least 1");
    end
  endgenerate

  logic [WIDTH-1:0] re_next;
  logic [WIDTH-1:0] fe_next;
  logic [WIDTH-1:0] pend_set;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      slib_edge_filter_ch #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
      ) u_ch (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .D       (D[i]),
        .Q       (Q[i]),
        .RE      (RE[i]),
        .FE      (FE[i]),
        .RE_NEXT (re_next[i]),
        .FE_NEXT (fe_next[i])
      );
    end
  endgenerate

  // MODE is qualified against the edge about to be registered, so a mode
  // change takes effect for an edge landing on the same clock.
  always_comb begin
    pend_set = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pend_set[i] = (re_next[i] & mode_rise(edge_mode_t'(MODE[2*i +: 2]))) |
                    (fe_next[i] & mode_fall(edge_mode_t'(MODE[2*i +: 2])));
    end
  end

  // Set has priority over clear so an edge coinciding with CLR is not lost.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      PEND <= '0;
    end else begin
      PEND <= pend_set | (PEND & ~CLR);
    end
  end

  assign IRQ = |PEND;

endmodule

// File: tb/tb_slib_edge_capture.sv
module tb_slib_edge_capture;

  logic CLK;

  // DUT A: 2-stage synchroniser, no filtering
  logic       a_rstn;
  logic [3:0] a_d, a_clr, a_q, a_re, a_fe, a_pend;
  logic [7:0] a_mode;
  logic       a_irq;

  // DUT B: no synchroniser, 4-cycle filter
  logic       b_rstn;
  logic [3:0] b_d, b_clr, b_q, b_re, b_fe, b_pend;
  logic [7:0] b_mode;
  logic       b_irq;

  int n_checks = 0;
  int n_fail   = 0;

  slib_edge_capture #(.WIDTH(4), .SYNC_STAGES(2), .FILTER_LEN(1)) dut_a (
    .CLK(CLK), .RSTN(a_rstn), .D(a_d), .MODE(a_mode), .CLR(a_clr),
    .Q(a_q), .RE(a_re), .FE(a_fe), .PEND(a_pend), .IRQ(a_irq)
  );

  slib_edge_capture #(.WIDTH(4), .SYNC_STAGES(0), .FILTER_LEN(4)) dut_b (
    .CLK(CLK), .RSTN(b_rstn), .D(b_d), .MODE(b_mode), .CLR(b_clr),
    .Q(b_q), .RE(b_re), .FE(b_fe), .PEND(b_pend), .IRQ(b_irq)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [3:0] d;
    logic [7:0] mode;
    logic [3:0] clr;
    logic [3:0] q;
    logic [3:0] re;
    logic [3:0] fe;
    logic [3:0] pend;
  } vec_t;

  vec_t vecs [16];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  int         re3, fe3;
  logic       other_bad;
  logic       d3;

  initial begin
    // Stimulus table for DUT A (2-cycle latency, Q[n] = D[n-2]).
    //                d        mode   clr      q        re       fe       pend
    vecs[0]  = '{4'b0001, 8'h55, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[1]  = '{4'b0001, 8'h55, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[2]  = '{4'b0001, 8'h55, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
    vecs[3]  = '{4'b0011, 8'h55, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
    vecs[4]  = '{4'b0011, 8'h55, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
    vecs[5]  = '{4'b0010, 8'hAA, 4'b0000, 4'b0011, 4'b0010, 4'b0000, 4'b0001};
    vecs[6]  = '{4'b0010, 8'hAA, 4'b0001, 4'b0011, 4'b0000, 4'b0000, 4'b0000};
    vecs[7]  = '{4'b0010, 8'hAA, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0001};
    vecs[8]  = '{4'b1010, 8'hFF, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0001};
    vecs[9]  = '{4'b1010, 8'hFF, 4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    vecs[10] = '{4'b1000, 8'h00, 4'b0000, 4'b1010, 4'b1000, 4'b0000, 4'b0000};
    vecs[11] = '{4'b1000, 8'hFF, 4'b1000, 4'b1010, 4'b0000, 4'b0000, 4'b0000};
    vecs[12] = '{4'b0000, 8'hFF, 4'b1000, 4'b1000, 4'b0000, 4'b0010, 4'b0010};
    vecs[13] = '{4'b0000, 8'hFF, 4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    vecs[14] = '{4'b0000, 8'hFF, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000};
    vecs[15] = '{4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};

    a_rstn = 1'b0; a_d = '0; a_mode = '0; a_clr = '0;
    b_rstn = 1'b0; b_d = '0; b_mode = '0; b_clr = '0;
    step(); step();
    chk("reset_a_outputs", {a_q, a_re, a_fe, a_pend, 3'b000, a_irq}, 32'h0);
    chk("reset_b_outputs", {b_q, b_re, b_fe, b_pend, 3'b000, b_irq}, 32'h0);
    a_rstn = 1'b1; b_rstn = 1'b1;
    step(); step(); step();
    chk("idle_a_outputs", {a_q, a_re, a_fe, a_pend, 3'b000, a_irq}, 32'h0);

    // ---------------- DUT A: vector table ----------------
    for (int i = 0; i < 16; i++) begin
      a_d = vecs[i].d; a_mode = vecs[i].mode; a_clr = vecs[i].clr;
      step();
      chk($sformatf("vec%0d_q", i),    a_q,    vecs[i].q);
      chk($sformatf("vec%0d_re", i),   a_re,   vecs[i].re);
      chk($sformatf("vec%0d_fe", i),   a_fe,   vecs[i].fe);
      chk($sformatf("vec%0d_pend", i), a_pend, vecs[i].pend);
      chk($sformatf("vec%0d_irq", i),  a_irq,  |vecs[i].pend);
    end

    // ---------------- DUT A: reset, then level high at release -------------
    a_d = 4'b1111; a_mode = 8'h55; a_clr = '0;
    step(); step(); step();
    a_rstn = 1'b0;
    step();
    chk("rst_a_q",    a_q,    4'h0);
    chk("rst_a_re",   a_re,   4'h0);
    chk("rst_a_fe",   a_fe,   4'h0);
    chk("rst_a_pend", a_pend, 4'h0);
    chk("rst_a_irq",  a_irq,  1'b0);
    a_rstn = 1'b1;
    step();
    chk("rel_a_q_k1", a_q, 4'h0);
    step();
    chk("rel_a_q_k2", a_q, 4'h0);
    step();
    chk("rel_a_q_k3",    a_q,    4'hF);
    chk("rel_a_re_k3",   a_re,   4'hF);
    chk("rel_a_pend_k3", a_pend, 4'hF);
    step();
    chk("rel_a_re_k4",   a_re,   4'h0);
    chk("rel_a_q_k4",    a_q,    4'hF);

    // ---------------- DUT B: 3-cycle glitch rejected ----------------
    for (int k = 0; k < 10; k++) begin
      b_d = (k < 3) ? 4'b0010 : 4'b0000;
      step();
      chk($sformatf("glitch3_k%0d_q1_re1", k), {b_q[1], b_re[1]}, 2'b00);
    end

    // ---------------- DUT B: 4-cycle pulse accepted ----------------
    for (int k = 0; k < 12; k++) begin
      b_d = (k < 4) ? 4'b0010 : 4'b0000;
      step();
      chk($sformatf("pulse4_k%0d_q1_re1_fe1", k), {b_q[1], b_re[1], b_fe[1]},
          {(k >= 3 && k <= 6) ? 1'b1 : 1'b0, (k == 3) ? 1'b1 : 1'b0, (k == 7) ? 1'b1 : 1'b0});
    end

    // ---------------- DUT B: mode gating ----------------
    b_mode = 8'b11_10_01_00;
    for (int k = 0; k < 12; k++) begin
      b_d = (k < 4) ? 4'b1111 : 4'b0000;
      step();
      if (k == 3) begin
        chk("gate_rise_re",   b_re,   4'b1111);
        chk("gate_rise_pend", b_pend, 4'b1010);
      end
      if (k == 7) begin
        chk("gate_fall_fe",   b_fe,   4'b1111);
        chk("gate_fall_pend", b_pend, 4'b1110);
      end
    end
    chk("gate_final_pend", b_pend, 4'b1110);

    // ---------------- DUT B: set/clear collision ----------------
    b_clr = 4'b1111;
    step();
    chk("coll_clear_all", b_pend, 4'b0000);
    b_clr = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      b_d = 4'b0100;
      step();
    end
    chk("coll_rise_no_pend", {b_q, b_pend}, {4'b0100, 4'b0000});
    for (int k = 0; k < 5; k++) begin
      b_d   = 4'b0000;
      b_clr = (k >= 3) ? 4'b0100 : 4'b0000;
      step();
      if (k == 3) begin
        chk("coll_fe2",         b_fe,   4'b0100);
        chk("coll_set_wins",    b_pend, 4'b0100);
      end
      if (k == 4) begin
        chk("coll_clear_pend",  b_pend, 4'b0000);
        chk("coll_clear_irq",   b_irq,  1'b0);
      end
    end
    b_clr = 4'b0000;

    // ---------------- DUT B: independence and sticky flag ----------------
    b_mode = 8'hC0;
    b_d    = 4'b0011;
    for (int k = 0; k < 6; k++) step();
    b_clr = 4'b1111;
    step();
    b_clr = 4'b0000;
    chk("indep_pre_pend", b_pend, 4'b0000);
    re3 = 0; fe3 = 0; other_bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      d3  = (k < 4) || (k >= 8 && k < 12);
      b_d = {d3, 3'b011};
      step();
      re3 += int'(b_re[3]);
      fe3 += int'(b_fe[3]);
      if ((b_re[2:0] | b_fe[2:0]) != 3'b000 || b_q[2:0] != 3'b011) other_bad = 1'b1;
    end
    chk("indep_re3_count", re3, 2);
    chk("indep_fe3_count", fe3, 2);
    chk("indep_others_quiet", other_bad, 1'b0);
    chk("indep_pend", b_pend, 4'b1000);
    b_mode = 8'h00;
    step(); step(); step();
    chk("sticky_mode0_pend", b_pend, 4'b1000);
    chk("sticky_mode0_irq",  b_irq,  1'b1);
    b_clr = 4'b1000;
    step();
    b_clr = 4'b0000;
    chk("sticky_clr_pend", b_pend, 4'b0000);
    chk("sticky_clr_irq",  b_irq,  1'b0);

    // ---------------- DUT B: reset mid-filter ----------------
    b_mode = 8'hC0;
    b_d    = 4'b1011;
    step(); step();
    b_rstn = 1'b0;
    step();
    chk("midrst_q", b_q, 4'b0000);
    b_rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("midrst_k%0d_q", k), b_q, (k >= 3) ? 4'b1011 : 4'b0000);
      if (k == 3) begin
        chk("midrst_re",   b_re,   4'b1011);
        chk("midrst_pend", b_pend, 4'b1000);
      end
      if (k == 4) chk("midrst_re_gone", b_re, 4'b0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
